tdm_demux8: RTL and testbench
=============================

# tdm_demux8

Time-division 8-way demultiplexer / deserializer: the receive end of the 8:1 mux. It owns the slot counter that drives the mux select, samples the mux's single-bit output once per enabled slot, and reassembles the 8 bits into a word. The word is presented downstream through a one-deep valid/ready output register. It sits between the serial 8:1 mux path and the parallel consumer logic.

## Interface

Parameters:
- WIDTH, 8, number of slots / output word width (power of two, >= 2)
- SEL_W, 3, select width, equal to log2(WIDTH)

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  synchronous active-low reset
- en  input  1  slot strobe; din is sampled and the slot advances on an edge where en=1
- sync  input  1  frame restart; discards the partial word and returns the slot to 0
- din  input  1  serial bit from the mux output (mux y)
- sel  output  SEL_W  current slot, drives the mux select (mux s)
- dout  output  WIDTH  reassembled word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  downstream accepts dout when dout_valid=1
- overrun  output  1  sticky: a completed word was dropped
- ovr_clr  input  1  clears overrun

## Operation

- Bit mapping: the din sampled in slot k goes to word bit k. Sweeping a mux input d=8'h55 over slots 0..7 yields dout=8'h55.
- Per edge, with rst_n=1, priority is:
  - sync=1: sel<=0, assembly register cleared, din ignored, en ignored. The output register and overrun are untouched.
  - else en=1: asm[sel]<=din, sel<=sel+1 mod WIDTH (wraps 7->0).
  - else: hold.
- Word completion: an en edge with sel=WIDTH-1 builds the word {din, asm[WIDTH-2:0]}.
  - Output register empty, or dout_valid=1 with dout_ready=1 on the same edge: load dout, set dout_valid=1.
  - Otherwise: discard the new word, keep the old dout, set overrun=1.
- Consumption: dout_valid && dout_ready with no concurrent completion clears dout_valid. dout holds its last value.
- overrun: set on a dropped word; cleared by ovr_clr. If set and clear happen on the same edge, set wins.
- The counter never stalls on backpressure, so sel stays in lockstep with the free-running mux.

## Timing

- Reset (rst_n=0 at an edge): sel=0, asm=0, dout=0, dout_valid=0, overrun=0. rst_n is checked ahead of every other input. Reset mid-frame discards the partial word and any pending dout.
- sel is registered and changes only on edges. The mux output din must be valid in the same cycle sel is shown (combinational mux, single-cycle path).
- Latency: dout/dout_valid are visible the cycle after the slot-7 sampling edge. Minimum word period is WIDTH enabled cycles.
- Back-to-back: with dout_ready held high and en=1 continuously, one word every 8 cycles and overrun stays 0.
- en gaps: slot and partial bits hold across any number of en=0 cycles.
- dout_ready is ignored while dout_valid=0.

## Structure

- Shared package (tdm_pkg): WIDTH default, SEL_W, and a slot-index type. The mux side imports the same constants.
- Sub-module tdm_slot_ctr: modulo-WIDTH counter with en, sync and wrap output (wrap = en && sel==WIDTH-1 && !sync). The top holds the assembly register, the output register and the overrun logic.
- Target size: about 150 RTL lines.

## Test plan

- Reset then sweep: d=8'h55 driven into a mux model on sel, en=1 for 8 cycles, dout_ready=1 -> dout=8'h55, dout_valid high one cycle after the 8th edge, sel back at 0.
- Continuous stream: words 8'hA3, 8'h0F, 8'hFF with en=1 throughout and dout_ready=1 -> three valid words 8 cycles apart, in order, overrun=0.
- Backpressure: dout_ready=0 across two full frames (8'h12, 8'h34) -> dout stays 8'h12 and overrun=1. Then ovr_clr=1 -> overrun=0. Then ready -> dout_valid drops.
- Simultaneous completion and consume: dout_valid=1 with ready=1 on the slot-7 edge of the next word 8'h9C -> dout=8'h9C, dout_valid stays 1, overrun=0.
- sync mid-frame: after 3 enabled slots assert sync (with en=1) -> sel=0 next cycle, then 8'hC5 sent -> dout=8'hC5 with no stale bits.
- Reset mid-operation: rst_n=0 at slot 5 with dout_valid=1 and overrun=1 -> all outputs zero next cycle. The next full frame 8'h81 is delivered correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants for the 8:1 TDM mux/demux pair: slot count, select width, slot index type.
// No logic; both the mux side and the demux side import it.
// No backpressure; constants only.
package tdm_pkg;

    localparam int WIDTH = 8;
    localparam int SEL_W = $clog2(WIDTH);

    typedef logic [SEL_W-1:0] slot_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-WIDTH slot counter driving the mux select; wrap flags the final enabled slot of a frame.
// sel is registered (updates on the enabling edge); wrap is combinational from current sel/en/sync.
// Never stalls: downstream backpressure has no effect, keeping sel in lockstep with the mux.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int WIDTH = tdm_pkg::WIDTH,
    parameter int SEL_W = tdm_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    output logic [SEL_W-1:0] sel,
    output logic             wrap
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel <= '0;
        end else if (sync) begin
            sel <= '0;
        end else if (en) begin
            sel <= (sel == LAST) ? '0 : sel + 1'b1;
        end
    end

    assign wrap = en && !sync && (sel == LAST);

endmodule

// File: rtl/tdm_demux8.sv
// TDM 8-way deserializer: samples din once per enabled slot and reassembles bit k from slot k.
// Word visible on dout/dout_valid one cycle after the last-slot sampling edge.
// One-deep valid/ready output; a word completing while the register is full and not drained is dropped and flags overrun.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int WIDTH = tdm_pkg::WIDTH,
    parameter int SEL_W = tdm_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             din,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             ovr_clr
);

    logic [WIDTH-1:0] asm_dat;
    logic [WIDTH-1:0] word_dat;
    logic             wrap;
    logic             load;
    logic             drop;

    tdm_slot_ctr #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .sync  (sync),
        .sel   (sel),
        .wrap  (wrap)
    );

    // The final bit bypasses asm so the word is complete on the wrapping edge itself.
    assign word_dat = {din, asm_dat[WIDTH-2:0]};
    assign load     = wrap && (!dout_valid || dout_ready);
    assign drop     = wrap && dout_valid && !dout_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_dat <= '0;
        end else if (sync) begin
            asm_dat <= '0;
        end else if (en) begin
            asm_dat[sel] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            dout       <= word_dat;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    // Set dominates clear so a drop on the clearing edge is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: a combinational mux model feeds din from mux_d[sel].
module tb_tdm_demux8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sync;
    logic       din;
    logic [2:0] sel;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       overrun;
    logic       ovr_clr;
    logic [7:0] mux_d;

    int vectors;
    int miscompares;

    tdm_demux8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sync       (sync),
        .din        (din),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    assign din = mux_d[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d);
        mux_d = d;
        en    = 1'b1;
        step(8);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        sync       = 1'b0;
        dout_ready = 1'b0;
        ovr_clr    = 1'b0;
        mux_d      = 8'h00;
        step(2);
        rst_n = 1'b1;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_dout", 32'(dout), 32'h00);
        chk("reset_valid", 32'(dout_valid), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);

        // Single sweep
        dout_ready = 1'b1;
        mux_d = 8'h55;
        en    = 1'b1;
        step(7);
        chk("sweep_valid_early", 32'(dout_valid), 32'd0);
        chk("sweep_sel7", 32'(sel), 32'd7);
        step(1);
        en = 1'b0;
        chk("sweep_dout", 32'(dout), 32'h55);
        chk("sweep_valid", 32'(dout_valid), 32'd1);
        chk("sweep_sel_wrap", 32'(sel), 32'd0);
        step(1);
        chk("sweep_consumed", 32'(dout_valid), 32'd0);
        chk("sweep_dout_hold", 32'(dout), 32'h55);

        // Continuous stream
        send_frame(8'hA3);
        chk("stream0_dout", 32'(dout), 32'hA3);
        chk("stream0_valid", 32'(dout_valid), 32'd1);
        mux_d = 8'h0F;
        step(4);
        chk("stream1_mid_valid", 32'(dout_valid), 32'd0);
        step(4);
        chk("stream1_dout", 32'(dout), 32'h0F);
        chk("stream1_valid", 32'(dout_valid), 32'd1);
        send_frame(8'hFF);
        en = 1'b0;
        chk("stream2_dout", 32'(dout), 32'hFF);
        chk("stream2_valid", 32'(dout_valid), 32'd1);
        chk("stream_overrun", 32'(overrun), 32'd0);
        step(1);
        chk("stream_drain", 32'(dout_valid), 32'd0);

        // Backpressure and overrun
        dout_ready = 1'b0;
        send_frame(8'h12);
        chk("bp0_dout", 32'(dout), 32'h12);
        chk("bp0_overrun", 32'(overrun), 32'd0);
        send_frame(8'h34);
        en = 1'b0;
        chk("bp1_dout_kept", 32'(dout), 32'h12);
        chk("bp1_overrun", 32'(overrun), 32'd1);
        chk("bp1_valid", 32'(dout_valid), 32'd1);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        chk("bp_ovr_clr", 32'(overrun), 32'd0);
        chk("bp_valid_held", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        step(1);
        chk("bp_drain", 32'(dout_valid), 32'd0);

        // Completion and consume on the same edge
        dout_ready = 1'b0;
        send_frame(8'h5A);
        mux_d = 8'h9C;
        step(7);
        chk("sim_pre_dout", 32'(dout), 32'h5A);
        chk("sim_pre_valid", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        step(1);
        en = 1'b0;
        chk("sim_dout", 32'(dout), 32'h9C);
        chk("sim_valid", 32'(dout_valid), 32'd1);
        chk("sim_overrun", 32'(overrun), 32'd0);
        step(1);
        chk("sim_drain", 32'(dout_valid), 32'd0);

        // en gaps hold slot and partial bits
        mux_d = 8'h3C;
        en    = 1'b1;
        step(3);
        en = 1'b0;
        mux_d = 8'h00;
        step(4);
        chk("gap_sel_hold", 32'(sel), 32'd3);
        mux_d = 8'h3C;
        en    = 1'b1;
        step(5);
        en = 1'b0;
        chk("gap_dout", 32'(dout), 32'h3C);
        chk("gap_valid", 32'(dout_valid), 32'd1);
        step(1);

        // sync mid-frame
        mux_d = 8'hFF;
        en    = 1'b1;
        step(3);
        chk("sync_pre_sel", 32'(sel), 32'd3);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("sync_sel", 32'(sel), 32'd0);
        chk("sync_no_word", 32'(dout_valid), 32'd0);
        send_frame(8'hC5);
        en = 1'b0;
        chk("sync_dout", 32'(dout), 32'hC5);
        chk("sync_valid", 32'(dout_valid), 32'd1);
        step(1);

        // Reset mid-operation
        dout_ready = 1'b0;
        send_frame(8'h11);
        send_frame(8'h22);
        chk("rst_pre_overrun", 32'(overrun), 32'd1);
        chk("rst_pre_valid", 32'(dout_valid), 32'd1);
        mux_d = 8'h81;
        step(5);
        chk("rst_pre_sel", 32'(sel), 32'd5);
        rst_n = 1'b0;
        step(1);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst_n      = 1'b1;
        dout_ready = 1'b1;
        send_frame(8'h81);
        en = 1'b0;
        chk("post_rst_dout", 32'(dout), 32'h81);
        chk("post_rst_valid", 32'(dout_valid), 32'd1);
        chk("post_rst_overrun", 32'(overrun), 32'd0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
